// File: rtl/res_net_iter_ctrl.sv
`default_nettype none
// res_net_iter_ctrl: N-factor XOR-binding resonator network with start/done iteration control.
// Optional o_iter_count port is enabled by defining RES_NET_ITER_CNT_EN.

package RES_NET_PKG;
    localparam int VECTOR_LEN        = 1024;
    localparam int NUM_CODEBOOK_BITS = 3;
    localparam int CB_SIZE           = 1 << NUM_CODEBOOK_BITS;

    typedef logic [CB_SIZE-1:0][VECTOR_LEN-1:0] cb_t;

    function automatic logic [31:0] mix32(input logic [31:0] i_x);
        logic [31:0] v;
        v = i_x;
        v = v ^ (v >> 16);
        v = v * 32'h7feb352d;
        v = v ^ (v >> 15);
        v = v * 32'h846ca68b;
        v = v ^ (v >> 16);
        return v;
    endfunction

    // Codebook of factor f: CB_SIZE pseudo-random, quasi-orthogonal codewords.
    function automatic cb_t XXT_TABLE(input int f);
        cb_t t;
        t = '0;
        for (int k = 0; k < CB_SIZE; k++)
            for (int w = 0; w < VECTOR_LEN / 32; w++)
                t[k][w*32 +: 32] = mix32({f[7:0], k[7:0], w[15:0]} ^ 32'h9e3779b9);
        return t;
    endfunction
endpackage

module factor_feature #(
    parameter int VECTOR_LEN        = RES_NET_PKG::VECTOR_LEN,
    parameter int NUM_CODEBOOK_BITS = RES_NET_PKG::NUM_CODEBOOK_BITS,
    parameter int FACTOR_IDX        = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [VECTOR_LEN-1:0] i_s_in,
    input  logic [VECTOR_LEN-1:0] i_o_hat_in,
    output logic [VECTOR_LEN-1:0] o_x_hat_out,
    output logic                  o_converged_out
);
    localparam int                c_CB_SIZE = 1 << NUM_CODEBOOK_BITS;
    localparam int                c_DIST_W  = $clog2(VECTOR_LEN + 1);
    localparam RES_NET_PKG::cb_t  c_CB      = RES_NET_PKG::XXT_TABLE(FACTOR_IDX);

    logic [VECTOR_LEN-1:0] w_unbound;
    logic [VECTOR_LEN-1:0] w_best;
    logic [c_DIST_W-1:0]   w_best_dist;
    logic [c_DIST_W-1:0]   w_dist;
    logic [VECTOR_LEN-1:0] r_x_hat;

    // Unbind the other factors, then clean up to the nearest codeword (lowest index wins ties).
    always_comb begin
        w_unbound   = i_s_in ^ i_o_hat_in;
        w_best      = c_CB[0][VECTOR_LEN-1:0];
        w_best_dist = c_DIST_W'($countones(w_unbound ^ c_CB[0][VECTOR_LEN-1:0]));
        w_dist      = w_best_dist;
        for (int k = 1; k < c_CB_SIZE; k++) begin
            w_dist = c_DIST_W'($countones(w_unbound ^ c_CB[k][VECTOR_LEN-1:0]));
            if (w_dist < w_best_dist) begin
                w_best_dist = w_dist;
                w_best      = c_CB[k][VECTOR_LEN-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_x_hat <= '0;
        else         r_x_hat <= w_best;
    end

    assign o_x_hat_out     = r_x_hat;
    assign o_converged_out = (w_best == r_x_hat);
endmodule

module res_net_iter_ctrl #(
    parameter int VECTOR_LEN        = RES_NET_PKG::VECTOR_LEN,
    parameter int NUM_CODEBOOK_BITS = RES_NET_PKG::NUM_CODEBOOK_BITS,
    parameter int NUM_FACTORS       = 3,
    parameter int MAX_ITERS         = 64,
    parameter int STABLE_ITERS      = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic                              i_start,
    input  logic                              i_abort,
    input  logic [VECTOR_LEN-1:0]             i_scene,
    input  logic [NUM_FACTORS*VECTOR_LEN-1:0] i_init,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_valid,
    output logic                              o_converged,
    output logic [NUM_FACTORS-1:0]            o_factor_converged,
    output logic [NUM_FACTORS*VECTOR_LEN-1:0] o_pred
`ifdef RES_NET_ITER_CNT_EN
    ,
    output logic [7:0]                        o_iter_count
`endif
);
    localparam logic [7:0] c_MAX_ITERS    = 8'(MAX_ITERS);
    localparam logic [7:0] c_STABLE_ITERS = 8'(STABLE_ITERS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                            r_state;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_valid;
    logic                              r_converged;
    logic [NUM_FACTORS-1:0]            r_factor_conv;
    logic [NUM_FACTORS*VECTOR_LEN-1:0] r_pred;
    logic [7:0]                        r_iter_cnt;
    logic [7:0]                        r_stable_cnt;

    logic [VECTOR_LEN-1:0]             w_est   [NUM_FACTORS];
    logic [VECTOR_LEN-1:0]             w_o_hat [NUM_FACTORS];
    logic [VECTOR_LEN-1:0]             w_x_hat [NUM_FACTORS];
    logic [NUM_FACTORS*VECTOR_LEN-1:0] w_x_flat;
    logic [NUM_FACTORS-1:0]            w_conv;
    logic [7:0]                        w_iter_inc;
    logic [7:0]                        w_stable_nxt;
    logic                              w_hit_stable;
    logic                              w_hit_max;

    // The INIT cycle feeds the supplied estimates; every other cycle closes the loop.
    always_comb begin
        w_x_flat = '0;
        for (int f = 0; f < NUM_FACTORS; f++) begin
            w_est[f] = (r_state == S_INIT) ? i_init[f*VECTOR_LEN +: VECTOR_LEN] : w_x_hat[f];
            w_x_flat[f*VECTOR_LEN +: VECTOR_LEN] = w_x_hat[f];
        end
        for (int f = 0; f < NUM_FACTORS; f++) begin
            w_o_hat[f] = '0;
            for (int g = 0; g < NUM_FACTORS; g++)
                if (g != f) w_o_hat[f] = w_o_hat[f] ^ w_est[g];
        end
    end

    for (genvar f = 0; f < NUM_FACTORS; f++) begin : g_factor
        factor_feature #(
            .VECTOR_LEN        (VECTOR_LEN),
            .NUM_CODEBOOK_BITS (NUM_CODEBOOK_BITS),
            .FACTOR_IDX        (f)
        ) u_factor (
            .i_clk           (i_clk),
            .i_rstn          (i_rstn),
            .i_s_in          (i_scene),
            .i_o_hat_in      (w_o_hat[f]),
            .o_x_hat_out     (w_x_hat[f]),
            .o_converged_out (w_conv[f])
        );
    end

    always_comb begin
        w_iter_inc   = (r_iter_cnt == 8'hFF) ? r_iter_cnt : r_iter_cnt + 8'd1;
        w_stable_nxt = 8'd0;
        if (&w_conv)
            w_stable_nxt = (r_stable_cnt == 8'hFF) ? r_stable_cnt : r_stable_cnt + 8'd1;
        w_hit_stable = (w_stable_nxt >= c_STABLE_ITERS);
        w_hit_max    = (w_iter_inc >= c_MAX_ITERS);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_valid       <= 1'b0;
            r_converged   <= 1'b0;
            r_factor_conv <= '0;
            r_pred        <= '0;
            r_iter_cnt    <= 8'd0;
            r_stable_cnt  <= 8'd0;
`ifdef RES_NET_ITER_CNT_EN
            o_iter_count  <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_abort) begin
                        r_valid <= 1'b0;
                    end else if (i_start) begin
                        r_state      <= S_INIT;
                        r_busy       <= 1'b1;
                        r_valid      <= 1'b0;
                        r_iter_cnt   <= 8'd0;
                        r_stable_cnt <= 8'd0;
                    end
                end
                S_INIT: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end else begin
                        r_iter_cnt   <= w_iter_inc;
                        r_stable_cnt <= w_stable_nxt;
                        if (w_hit_stable || w_hit_max) begin
                            r_state       <= S_DONE;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_valid       <= 1'b1;
                            r_converged   <= w_hit_stable;
                            r_factor_conv <= w_conv;
                            r_pred        <= w_x_flat;
`ifdef RES_NET_ITER_CNT_EN
                            o_iter_count  <= w_iter_inc;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    if (i_abort) r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_valid            = r_valid;
    assign o_converged        = r_converged;
    assign o_factor_converged = r_factor_conv;
    assign o_pred             = r_pred;
endmodule

`default_nettype wire

// File: tb/tb_res_net_iter_ctrl.sv
`default_nettype none
// Self-checking bench for res_net_iter_ctrl: resonator behaviour model plus control-path scenarios.
module tb_res_net_iter_ctrl;
    localparam int VL = 1024;
    typedef logic [VL-1:0]      vec_t;
    typedef logic [3:0][VL-1:0] est_t;

    logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, start4 = 1'b0;
    vec_t scene = '0, scene4 = '0;
    logic [3*VL-1:0] init3 = '0;
    logic [4*VL-1:0] init4 = '0;

    logic busy3, done3, valid3, conv3, busy1, done1, valid1, conv1, busy4, done4, valid4, conv4;
    logic [2:0] fc3, fc1;
    logic [3:0] fc4;
    logic [3*VL-1:0] pred3, pred1;
    logic [4*VL-1:0] pred4;
`ifdef RES_NET_ITER_CNT_EN
    logic [7:0] it3, it1, it4;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    res_net_iter_ctrl #(.VECTOR_LEN(VL), .NUM_CODEBOOK_BITS(3), .NUM_FACTORS(3), .MAX_ITERS(64), .STABLE_ITERS(2)) u3 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort), .i_scene(scene), .i_init(init3),
        .o_busy(busy3), .o_done(done3), .o_valid(valid3), .o_converged(conv3),
        .o_factor_converged(fc3), .o_pred(pred3)
`ifdef RES_NET_ITER_CNT_EN
        , .o_iter_count(it3)
`endif
    );
    res_net_iter_ctrl #(.VECTOR_LEN(VL), .NUM_CODEBOOK_BITS(3), .NUM_FACTORS(3), .MAX_ITERS(1), .STABLE_ITERS(2)) u1 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort), .i_scene(scene), .i_init(init3),
        .o_busy(busy1), .o_done(done1), .o_valid(valid1), .o_converged(conv1),
        .o_factor_converged(fc1), .o_pred(pred1)
`ifdef RES_NET_ITER_CNT_EN
        , .o_iter_count(it1)
`endif
    );
    res_net_iter_ctrl #(.VECTOR_LEN(VL), .NUM_CODEBOOK_BITS(3), .NUM_FACTORS(4), .MAX_ITERS(64), .STABLE_ITERS(2)) u4 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start4), .i_abort(abort), .i_scene(scene4), .i_init(init4),
        .o_busy(busy4), .o_done(done4), .o_valid(valid4), .o_converged(conv4),
        .o_factor_converged(fc4), .o_pred(pred4)
`ifdef RES_NET_ITER_CNT_EN
        , .o_iter_count(it4)
`endif
    );

    // ---------------- reference model ----------------
    function automatic vec_t cw(input int f, input int k);
        RES_NET_PKG::cb_t t;
        t = RES_NET_PKG::XXT_TABLE(f);
        return t[k];
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int w = 0; w < VL / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic vec_t nearest(input int f, input vec_t u);
        vec_t b;
        int bd, d;
        b  = cw(f, 0);
        bd = $countones(u ^ b);
        for (int k = 1; k < 8; k++) begin
            d = $countones(u ^ cw(f, k));
            if (d < bd) begin bd = d; b = cw(f, k); end
        end
        return b;
    endfunction

    function automatic est_t step(input int nf, input vec_t s, input est_t x);
        est_t n;
        vec_t others;
        n = '0;
        for (int f = 0; f < nf; f++) begin
            others = '0;
            for (int g = 0; g < nf; g++) if (g != f) others ^= x[g];
            n[f] = nearest(f, s ^ others);
        end
        return n;
    endfunction

    // Estimates after INIT are step(init); iteration k compares step(x_k) against x_k.
    task automatic model(input int nf, input int maxit, input vec_t s, input est_t init,
                         output est_t pred, output logic [3:0] fc, output logic cv, output int iters);
        est_t x, nx;
        int stable;
        logic [3:0] mask;
        mask = 4'((1 << nf) - 1);
        x = step(nf, s, init);
        stable = 0; pred = x; fc = '0; cv = 1'b0; iters = maxit;
        for (int k = 1; k <= maxit; k++) begin
            nx = step(nf, s, x);
            fc = '0;
            for (int f = 0; f < nf; f++) fc[f] = (nx[f] == x[f]);
            stable = (fc == mask) ? stable + 1 : 0;
            if (stable >= 2 || k == maxit) begin
                pred = x; cv = (stable >= 2); iters = k;
                break;
            end
            x = nx;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    // First o_done cycle of each 3-factor instance and of u4, counted from the cycle after the start edge.
    task automatic run_wait(input int budget, input int target, output int c3, output int c1, output int c4);
        c3 = -1; c1 = -1; c4 = -1;
        for (int c = 1; c <= budget; c++) begin
            if (done3 && c3 < 0) c3 = c;
            if (done1 && c1 < 0) c1 = c;
            if (done4 && c4 < 0) c4 = c;
            if ((target == 0 && c3 >= 0) || (target == 1 && c1 >= 0) || (target == 2 && c4 >= 0)) break;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick();
        total++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin bad++; $display("FAIL reset_busy_done got %b%b want 00", busy3, done3); end
        total++; if (valid3 !== 1'b0 || conv3 !== 1'b0) begin bad++; $display("FAIL reset_valid_conv got %b%b want 00", valid3, conv3); end
        total++; if (fc3 !== 3'b000) begin bad++; $display("FAIL reset_fc got %b want 000", fc3); end
        total++; if (pred3 !== '0) begin bad++; $display("FAIL reset_pred got %h want 0", pred3[31:0]); end
`ifdef RES_NET_ITER_CNT_EN
        total++; if (it3 !== 8'd0) begin bad++; $display("FAIL reset_iter got %0d want 0", it3); end
`endif
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_converge();
        vec_t c0, s5, p2;
        int d3, d1, d4;
        c0 = cw(0, 0); s5 = cw(1, 5); p2 = cw(2, 2);
        scene = c0 ^ s5 ^ p2;
        init3 = {p2, s5, c0};
        pulse_start();
        run_wait(20, 0, d3, d1, d4);
        total++; if (d3 != 4) begin bad++; $display("FAIL conv_done_cycle got %0d want 4", d3); end
        total++; if (conv3 !== 1'b1) begin bad++; $display("FAIL conv_flag got %b want 1", conv3); end
        total++; if (fc3 !== 3'b111) begin bad++; $display("FAIL conv_fc got %b want 111", fc3); end
        total++; if (pred3 !== {p2, s5, c0}) begin bad++; $display("FAIL conv_pred got %h want %h", pred3[31:0], c0[31:0]); end
        total++; if (busy3 !== 1'b0 || valid3 !== 1'b1) begin bad++; $display("FAIL conv_busy_valid got %b%b want 01", busy3, valid3); end
`ifdef RES_NET_ITER_CNT_EN
        total++; if (it3 !== 8'd2) begin bad++; $display("FAIL conv_iter got %0d want 2", it3); end
`endif
        tick();
        total++; if (done3 !== 1'b0 || valid3 !== 1'b1) begin bad++; $display("FAIL conv_after got done=%b valid=%b want 0 1", done3, valid3); end
    endtask

    task automatic test_timeout();
        est_t ini, p;
        logic [3:0] fc;
        logic cv;
        int it, d3, d1, d4;
        scene = rand_vec();
        for (int f = 0; f < 3; f++) begin ini[f] = rand_vec(); init3[f*VL +: VL] = ini[f]; end
        ini[3] = '0;
        model(3, 1, scene, ini, p, fc, cv, it);
        pulse_start();
        run_wait(80, 0, d3, d1, d4);
        total++; if (d1 != 3) begin bad++; $display("FAIL tmo_done_cycle got %0d want 3", d1); end
        total++; if (conv1 !== 1'b0) begin bad++; $display("FAIL tmo_conv got %b want 0", conv1); end
        total++; if (valid1 !== 1'b1) begin bad++; $display("FAIL tmo_valid got %b want 1", valid1); end
        for (int f = 0; f < 3; f++) begin
            total++; if (pred1[f*VL +: VL] !== p[f]) begin bad++; $display("FAIL tmo_pred%0d got %h want %h", f, pred1[f*VL +: 32], p[f][31:0]); end
        end
`ifdef RES_NET_ITER_CNT_EN
        total++; if (it1 !== 8'd1) begin bad++; $display("FAIL tmo_iter got %0d want 1", it1); end
`endif
        tick();
    endtask

    task automatic test_random();
        est_t ini, p;
        logic [3:0] fc;
        logic cv;
        int it, d3, d1, d4, mode;
        for (int r = 0; r < 6; r++) begin
            mode = r % 3;
            scene = '0;
            ini = '0;
            for (int f = 0; f < 3; f++) begin
                scene ^= cw(f, $urandom_range(0, 7));
                ini[f] = (mode == 0) ? nearest(f, scene) : (mode == 1) ? cw(f, $urandom_range(0, 7)) : rand_vec();
            end
            if (mode == 0) for (int f = 0; f < 3; f++) ini[f] = ini[f] ^ (rand_vec() & rand_vec() & rand_vec());
            for (int f = 0; f < 3; f++) init3[f*VL +: VL] = ini[f];
            model(3, 64, scene, ini, p, fc, cv, it);
            pulse_start();
            run_wait(80, 0, d3, d1, d4);
            total++; if (d3 != it + 2) begin bad++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", r, d3, it + 2); end
            total++; if (conv3 !== cv || fc3 !== fc[2:0]) begin bad++; $display("FAIL rnd%0d_conv got %b/%b want %b/%b", r, conv3, fc3, cv, fc[2:0]); end
            for (int f = 0; f < 3; f++) begin
                total++; if (pred3[f*VL +: VL] !== p[f]) begin bad++; $display("FAIL rnd%0d_pred%0d got %h want %h", r, f, pred3[f*VL +: 32], p[f][31:0]); end
            end
`ifdef RES_NET_ITER_CNT_EN
            total++; if (it3 !== 8'(it)) begin bad++; $display("FAIL rnd%0d_iter got %0d want %0d", r, it3, it); end
`endif
            tick();
        end
    endtask

    task automatic test_start_ignored();
        int ndone, first, d3, d1, d4;
        scene = cw(0, 3) ^ cw(1, 1) ^ cw(2, 6);
        init3 = {cw(2, 6), cw(1, 1), cw(0, 3)};
        pulse_start();
        ndone = 0; first = -1;
        for (int c = 1; c <= 12; c++) begin
            start = (c <= 3);
            if (done3) begin ndone++; if (first < 0) first = c; end
            tick();
        end
        start = 1'b0;
        total++; if (ndone != 1 || first != 4) begin bad++; $display("FAIL restart_ignored got %0d dones first=%0d want 1 at 4", ndone, first); end
        // back-to-back: start in the cycle right after o_done
        pulse_start();
        run_wait(20, 0, d3, d1, d4);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        total++; if (valid3 !== 1'b0 || busy3 !== 1'b1) begin bad++; $display("FAIL b2b_start got valid=%b busy=%b want 0 1", valid3, busy3); end
        run_wait(20, 0, d3, d1, d4);
        total++; if (d3 != 4 || conv3 !== 1'b1) begin bad++; $display("FAIL b2b_done got cycle %0d conv %b want 4 1", d3, conv3); end
        tick();
    endtask

    task automatic test_abort();
        logic [3*VL-1:0] prev;
        int ndone;
        prev = pred3;
        scene = cw(0, 7) ^ cw(1, 2) ^ cw(2, 4);
        init3 = {cw(2, 4), cw(1, 2), cw(0, 7)};
        pulse_start();
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        total++; if (busy3 !== 1'b0 || valid3 !== 1'b0 || done3 !== 1'b0) begin bad++; $display("FAIL abort_state got busy=%b valid=%b done=%b want 000", busy3, valid3, done3); end
        ndone = 0;
        for (int c = 0; c < 8; c++) begin if (done3) ndone++; tick(); end
        total++; if (ndone != 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", ndone); end
        total++; if (pred3 !== prev) begin bad++; $display("FAIL abort_pred_kept got %h want %h", pred3[31:0], prev[31:0]); end
    endtask

    task automatic test_reset_mid();
        int d3, d1, d4;
        scene = cw(0, 1) ^ cw(1, 4) ^ cw(2, 0);
        init3 = {cw(2, 0), cw(1, 4), cw(0, 1)};
        pulse_start();
        tick();
        #2 rstn = 1'b0;
        #1;
        total++; if ({busy3, done3, valid3, conv3} !== 4'b0000 || fc3 !== 3'b000 || pred3 !== '0) begin
            bad++; $display("FAIL rst_mid got busy=%b done=%b valid=%b conv=%b fc=%b want all 0", busy3, done3, valid3, conv3, fc3); end
        tick();
        rstn = 1'b1;
        tick();
        pulse_start();
        run_wait(20, 0, d3, d1, d4);
        total++; if (d3 != 4 || conv3 !== 1'b1 || fc3 !== 3'b111) begin bad++; $display("FAIL rst_rerun got cycle %0d conv %b fc %b want 4 1 111", d3, conv3, fc3); end
        tick();
    endtask

    task automatic test_four_factors();
        vec_t c [4];
        int d3, d1, d4;
        scene4 = '0;
        for (int f = 0; f < 4; f++) begin
            c[f] = cw(f, $urandom_range(0, 7));
            scene4 ^= c[f];
            init4[f*VL +: VL] = c[f];
        end
        start4 = 1'b1; tick(); start4 = 1'b0;
        run_wait(20, 2, d3, d1, d4);
        total++; if (d4 != 4 || conv4 !== 1'b1) begin bad++; $display("FAIL nf4_done got cycle %0d conv %b want 4 1", d4, conv4); end
        total++; if (fc4 !== 4'b1111) begin bad++; $display("FAIL nf4_fc got %b want 1111", fc4); end
        for (int f = 0; f < 4; f++) begin
            total++; if (pred4[f*VL +: VL] !== c[f]) begin bad++; $display("FAIL nf4_pred%0d got %h want %h", f, pred4[f*VL +: 32], c[f][31:0]); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_converge();
        test_timeout();
        test_random();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_four_factors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/res_net_iter_ctrl.md
# res_net_iter_ctrl

- Parametrised N-factor resonator network with an iteration controller.
- Generalises the fixed three-factor resonator top to NUM_FACTORS factors.
- Adds a start/done handshake, one-cycle initial-estimate load, consecutive-cycle convergence qualification, iteration timeout and abort.
- Sits between the scene encoder and the downstream result consumer; one factorisation runs at a time.

## Interface

Parameters:
- VECTOR_LEN, default RES_NET_PKG::VECTOR_LEN: hypervector width in bits.
- NUM_CODEBOOK_BITS, default RES_NET_PKG::NUM_CODEBOOK_BITS: passed to each factor_feature.
- NUM_FACTORS, default 3: factor count; legal range 2..8. Factor f uses codebook RES_NET_PKG::XXT_TABLE[f].
- MAX_ITERS, default 64: iteration limit; legal range 1..255.
- STABLE_ITERS, default 2: consecutive all-converged iterations required; legal range 1..MAX_ITERS.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous assert, active-low. One clock domain: i_clk.
- i_start  in  1  start request; sampled only in IDLE.
- i_abort  in  1  abandon the current run.
- i_scene  in  VECTOR_LEN  scene hypervector; must be held stable from start until o_done.
- i_init  in  NUM_FACTORS*VECTOR_LEN  initial estimates; factor f occupies bits [f*VECTOR_LEN +: VECTOR_LEN]; sampled in INIT.
- o_busy  out  1  high in INIT and ITER.
- o_done  out  1  one-cycle pulse when a run finishes.
- o_valid  out  1  level; results valid. Set with o_done, cleared by the next accepted start or by abort.
- o_converged  out  1  run finished by convergence (1) or by timeout (0).
- o_factor_converged  out  NUM_FACTORS  per-factor converged_out, latched at finish.
- o_pred  out  NUM_FACTORS*VECTOR_LEN  latched predictions, same packing as i_init.
- o_iter_count  out  8  iterations executed; present only with RES_NET_ITER_CNT_EN.

## Operation

- Binding is bitwise XOR.
  - o_hat[f] is the XOR of the estimates of all factors except f.
  - In INIT, estimates are i_init slices; otherwise they are the x_hat_out values of the factor_feature instances.
- Per-factor datapath:
  - One factor_feature per factor, with inputs s_in=i_scene and o_hat_in=o_hat[f].
  - x_hat_out is registered and updates every clock.
  - converged_out=1 when the new x_hat equals the previous one.
- FSM states: IDLE, INIT, ITER, DONE.
- FSM transitions:
  - IDLE -> INIT: on i_start. Clears o_valid, iter_cnt and stable_cnt.
  - INIT -> ITER: unconditional, after 1 cycle.
  - In ITER, each cycle is one iteration:
    - iter_cnt increments.
    - stable_cnt increments if all converged_out are high, otherwise it clears to 0.
  - ITER -> DONE: when stable_cnt reaches STABLE_ITERS (converged=1) or iter_cnt reaches MAX_ITERS (converged=0). If both occur on the same edge, converged=1.
  - On the ITER->DONE edge, o_pred, o_factor_converged, o_converged and the iteration count are captured.
  - DONE -> IDLE: after 1 cycle. o_done is high in DONE; o_valid is set.
- i_abort in INIT, ITER or DONE: next state IDLE, o_valid=0, no o_done. Abort takes priority over convergence and timeout.
- i_abort in IDLE: clears o_valid.
- i_start is ignored outside IDLE.
- If i_start and i_abort are both high in IDLE, abort wins and no run starts.
- Counters are 8 bits and saturate; they never wrap (MAX_ITERS ≤ 255 guarantees this).

## Timing

- Reset values:
  - State IDLE.
  - o_busy, o_done, o_valid, o_converged = 0.
  - o_factor_converged = 0, o_pred = 0, o_iter_count = 0, internal counters = 0.
- Reset asserted mid-run returns the block to IDLE immediately. No o_done is produced.
- Start sampled at edge 0:
  - INIT in cycle 1.
  - ITER from cycle 2.
  - Earliest o_done in cycle STABLE_ITERS+2.
  - Timeout o_done in cycle MAX_ITERS+2.
- o_busy deasserts in the same cycle that o_done asserts.
- The earliest next start is the cycle after o_done.
- Outputs change only on the ITER->DONE edge, on reset, or when o_valid clears.

## Configuration

- Macro RES_NET_ITER_CNT_EN.
- Defined:
  - The o_iter_count port exists.
  - It holds the iteration count captured at finish (1..MAX_ITERS).
  - It resets to 0.
- Undefined:
  - The port and its capture register are absent.
  - The internal iter_cnt still drives the timeout.

## Test plan

All scenarios use VECTOR_LEN=1024, NUM_FACTORS=3 and STABLE_ITERS=2 unless stated.

- Scene = XOR of codewords c0, s5, p2; i_init = those exact codewords; start at edge 0 -> o_done in cycle 4, o_converged=1, o_factor_converged=3'b111, o_pred={p2,s5,c0}, o_iter_count=2.
- MAX_ITERS=1, any scene/init -> o_done in cycle 3, o_converged=0, o_iter_count=1, o_valid=1 afterwards.
- Convergence scene, with i_start pulsed again in cycles 1..3 -> ignored. Exactly one o_done. A start in the cycle after o_done clears o_valid and runs again.
- i_abort in cycle 2 of a run -> IDLE next cycle, o_busy=0, o_valid=0, no o_done, previous o_pred retained.
- i_rstn low in cycle 2 -> all outputs 0 and state IDLE asynchronously. After release, a new start completes normally.
- NUM_FACTORS=4 with codewords of factors 0..3 bound and used as init -> o_done in cycle 4, o_factor_converged=4'b1111, all four slices of o_pred correct.
